// File: rtl/sram_pkg.sv
// Shared types and configuration helpers for the sram_dp buffer.
package sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  function automatic int unsigned be_width(input int unsigned data_width);
    return data_width / BYTE_W;
  endfunction

  // True when the parameter set describes a buildable memory.
  function automatic bit cfg_legal(input int unsigned data_width,
                                   input int unsigned addr_width,
                                   input int unsigned mem_depth,
                                   input int unsigned rd_latency);
    return (data_width != 0) && ((data_width % BYTE_W) == 0) &&
           (rd_latency >= RD_LAT_MIN) && (rd_latency <= RD_LAT_MAX) &&
           (mem_depth != 0) && (addr_width < 32) &&
           (mem_depth <= (32'd1 << addr_width));
  endfunction

endpackage

// File: rtl/sram_dp_if.sv
// Write/read port bundle of the dual-port SRAM; master drives requests, slave is the memory.
interface sram_dp_if
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 11
);
  localparam int unsigned BE_WIDTH = be_width(DATA_WIDTH);

  logic                  ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_be;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    input  ready, rd_data, rd_valid,
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr
  );

  modport slave (
    output ready, rd_data, rd_valid,
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr
  );

endinterface

// File: rtl/sram_init_ctrl.sv
// Post-reset zero-fill sequencer: walks every address once, then raises ready.
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned MEM_DEPTH  = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  init_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  ready_q, ready_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    case (state_q)
      INIT: begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == LAST_ADDR) begin
          state_d = READY;
          ready_d = 1'b1;
          ptr_d   = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  assign ready     = ready_q;
  assign init_we   = ~ready_q;
  assign init_addr = ptr_q;

endmodule

// File: rtl/sram_dp.sv
// Simple dual-port SRAM with byte enables, 1/2-cycle registered reads and hardware zero-init.
// Define SRAM_BYPASS_EN for write-first same-address collisions; default is read-first.
module sram_dp
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned MEM_DEPTH  = 2048,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst,
  sram_dp_if.slave  bus
);

  localparam int unsigned         BE_WIDTH  = be_width(DATA_WIDTH);
  localparam int unsigned         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  if (!cfg_legal(DATA_WIDTH, ADDR_WIDTH, MEM_DEPTH, RD_LATENCY)) begin : g_bad_cfg
    $error("sram_dp: illegal DATA_WIDTH/ADDR_WIDTH/MEM_DEPTH/RD_LATENCY combination");
  end

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  ready;
  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  wr_hit_c;
  logic                  rd_acc_c;
  logic                  rd_in_range_c;
  logic                  fwd_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  logic                  s0_valid;
  logic [DATA_WIDTH-1:0] s0_data;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  sram_init_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_init_ctrl (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  assign bus.ready     = ready;
  assign wr_hit_c      = ready & bus.wr_en & ({1'b0, bus.wr_addr} < DEPTH_LIM);
  assign rd_acc_c      = ready & bus.rd_en;
  assign rd_in_range_c = {1'b0, bus.rd_addr} < DEPTH_LIM;

`ifdef SRAM_BYPASS_EN
  assign fwd_c = wr_hit_c & (bus.wr_addr == bus.rd_addr);
`else
  assign fwd_c = 1'b0;
`endif

  // Array port: init sweep has priority, user writes only touch enabled bytes.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[IDX_W'(init_addr)] <= '0;
    end else if (wr_hit_c) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (bus.wr_be[i]) begin
          mem[IDX_W'(bus.wr_addr)][i*BYTE_W +: BYTE_W] <= bus.wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read word: old contents, zero when out of range, enabled bytes forwarded on collision.
  always_comb begin
    rd_word_c = rd_in_range_c ? mem[IDX_W'(bus.rd_addr)] : '0;
    if (fwd_c) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (bus.wr_be[i]) begin
          rd_word_c[i*BYTE_W +: BYTE_W] = bus.wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s0_valid <= rd_acc_c;
      if (rd_acc_c) s0_data <= rd_word_c;
      s1_valid <= s0_valid;
      if (s0_valid) s1_data <= s0_data;
    end
  end

  if (RD_LATENCY == RD_LAT_MAX) begin : g_out_reg
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign bus.rd_valid = s2_valid;
    assign bus.rd_data  = s2_data;
  end else begin : g_no_out_reg
    assign bus.rd_valid = s1_valid;
    assign bus.rd_data  = s1_data;
  end

endmodule

// File: tb/tb_sram_dp.sv
// Directed bench for sram_dp: one latency-1 instance (11-bit addr) and one latency-2 instance (12-bit addr).
module tb_sram_dp;

  typedef struct packed {
    logic        v1;
    logic [15:0] d1;
    logic        v1h;
    logic [15:0] d1h;
    logic        v2;
    logic [15:0] d2;
  } obs_t;

`ifdef SRAM_BYPASS_EN
  localparam logic [15:0] COL_FULL = 16'hAAAA;
  localparam logic [15:0] COL_PART = 16'hAA11;
`else
  localparam logic [15:0] COL_FULL = 16'h5555;
  localparam logic [15:0] COL_PART = 16'hAAAA;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sram_dp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(11)) b1 ();
  sram_dp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) b2 ();

  sram_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .MEM_DEPTH(2048), .RD_LATENCY(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (b1)
  );

  sram_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .MEM_DEPTH(2048), .RD_LATENCY(2)) u_dut2 (
    .clk (clk), .rst (rst), .bus (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit to1, input bit to2, input bit we, input logic [11:0] wa,
                       input logic [15:0] wd, input logic [1:0] be, input bit re,
                       input logic [11:0] ra);
    b1.wr_en = to1 & we; b1.wr_addr = wa[10:0]; b1.wr_data = wd; b1.wr_be = be;
    b1.rd_en = to1 & re; b1.rd_addr = ra[10:0];
    b2.wr_en = to2 & we; b2.wr_addr = wa;       b2.wr_data = wd; b2.wr_be = be;
    b2.rd_en = to2 & re; b2.rd_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 2'b00, 1'b0, 12'h0);
  endtask

  task automatic step(input bit to1, input bit to2, input bit we, input logic [11:0] wa,
                      input logic [15:0] wd, input logic [1:0] be, input bit re,
                      input logic [11:0] ra);
    drive(to1, to2, we, wa, wd, be, re, ra);
    @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] a, input logic [15:0] d, input logic [1:0] be);
    step(1'b1, 1'b1, 1'b1, a, d, be, 1'b0, 12'h0);
    idle();
  endtask

  // One request on both instances; captures L1 output after N+1 and N+2, L2 output after N+2.
  task automatic xact(input bit we, input logic [11:0] wa, input logic [15:0] wd,
                      input logic [1:0] be, input logic [11:0] ra, output obs_t o);
    step(1'b1, 1'b1, we, wa, wd, be, 1'b1, ra);
    idle();
    @(negedge clk);
    o.v1 = b1.rd_valid; o.d1 = b1.rd_data;
    @(negedge clk);
    o.v1h = b1.rd_valid; o.d1h = b1.rd_data;
    o.v2 = b2.rd_valid;  o.d2 = b2.rd_data;
  endtask

  task automatic test_reset();
    obs_t o;
    int   cnt;
    rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({b1.ready, b1.rd_valid, b1.rd_data} !== 18'h0) begin
      n_err++; $display("FAIL reset_l1: got rdy=%b v=%b d=%h want 0/0/0000", b1.ready, b1.rd_valid, b1.rd_data);
    end
    n_cmp++;
    if ({b2.ready, b2.rd_valid, b2.rd_data} !== 18'h0) begin
      n_err++; $display("FAIL reset_l2: got rdy=%b v=%b d=%h want 0/0/0000", b2.ready, b2.rd_valid, b2.rd_data);
    end
    rst = 1'b0;
    cnt = 0;
    while (b1.ready !== 1'b1 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (cnt !== 2048) begin
      n_err++; $display("FAIL init_duration: ready after %0d edges want 2048", cnt);
    end
    n_cmp++;
    if (b2.ready !== 1'b1) begin
      n_err++; $display("FAIL init_ready_l2: got %b want 1", b2.ready);
    end
    xact(1'b0, 12'h0, 16'h0, 2'b00, 12'h005, o);
    n_cmp++;
    if ({o.v1, o.d1, o.v2, o.d2} !== {1'b1, 16'h0000, 1'b1, 16'h0000}) begin
      n_err++; $display("FAIL init_read_005: got %b/%h %b/%h want 1/0000 1/0000", o.v1, o.d1, o.v2, o.d2);
    end
  endtask

  task automatic test_basic_rw();
    obs_t o;
    wr(12'h010, 16'hBEEF, 2'b11);
    xact(1'b0, 12'h0, 16'h0, 2'b00, 12'h010, o);
    n_cmp++;
    if ({o.v1, o.d1, o.v2, o.d2} !== {1'b1, 16'hBEEF, 1'b1, 16'hBEEF}) begin
      n_err++; $display("FAIL basic_read: got %b/%h %b/%h want 1/beef 1/beef", o.v1, o.d1, o.v2, o.d2);
    end
    n_cmp++;
    if ({o.v1h, o.d1h} !== {1'b0, 16'hBEEF}) begin
      n_err++; $display("FAIL basic_hold_l1: got %b/%h want 0/beef", o.v1h, o.d1h);
    end
  endtask

  task automatic test_byte_enable();
    obs_t o;
    wr(12'h010, 16'h1234, 2'b01);
    xact(1'b0, 12'h0, 16'h0, 2'b00, 12'h010, o);
    n_cmp++;
    if ({o.v1, o.d1, o.v2, o.d2} !== {1'b1, 16'hBE34, 1'b1, 16'hBE34}) begin
      n_err++; $display("FAIL be_low: got %b/%h %b/%h want 1/be34 1/be34", o.v1, o.d1, o.v2, o.d2);
    end
    wr(12'h010, 16'hFFFF, 2'b00);
    xact(1'b0, 12'h0, 16'h0, 2'b00, 12'h010, o);
    n_cmp++;
    if ({o.v1, o.d1, o.v2, o.d2} !== {1'b1, 16'hBE34, 1'b1, 16'hBE34}) begin
      n_err++; $display("FAIL be_none: got %b/%h %b/%h want 1/be34 1/be34", o.v1, o.d1, o.v2, o.d2);
    end
    wr(12'h010, 16'h5600, 2'b10);
    xact(1'b0, 12'h0, 16'h0, 2'b00, 12'h010, o);
    n_cmp++;
    if ({o.v1, o.d1, o.v2, o.d2} !== {1'b1, 16'h5634, 1'b1, 16'h5634}) begin
      n_err++; $display("FAIL be_high: got %b/%h %b/%h want 1/5634 1/5634", o.v1, o.d1, o.v2, o.d2);
    end
  endtask

  task automatic test_collision();
    obs_t o;
    wr(12'h020, 16'h5555, 2'b11);
    xact(1'b1, 12'h020, 16'hAAAA, 2'b11, 12'h020, o);
    n_cmp++;
    if ({o.v1, o.d1, o.v2, o.d2} !== {1'b1, COL_FULL, 1'b1, COL_FULL}) begin
      n_err++; $display("FAIL coll_full: got %b/%h %b/%h want 1/%h", o.v1, o.d1, o.v2, o.d2, COL_FULL);
    end
    xact(1'b1, 12'h020, 16'h0011, 2'b01, 12'h020, o);
    n_cmp++;
    if ({o.v1, o.d1, o.v2, o.d2} !== {1'b1, COL_PART, 1'b1, COL_PART}) begin
      n_err++; $display("FAIL coll_part: got %b/%h %b/%h want 1/%h", o.v1, o.d1, o.v2, o.d2, COL_PART);
    end
    xact(1'b1, 12'h030, 16'h7777, 2'b11, 12'h020, o);
    n_cmp++;
    if ({o.v1, o.d1, o.v2, o.d2} !== {1'b1, 16'hAA11, 1'b1, 16'hAA11}) begin
      n_err++; $display("FAIL indep_rd: got %b/%h %b/%h want 1/aa11", o.v1, o.d1, o.v2, o.d2);
    end
    xact(1'b0, 12'h0, 16'h0, 2'b00, 12'h030, o);
    n_cmp++;
    if ({o.v1, o.d1, o.v2, o.d2} !== {1'b1, 16'h7777, 1'b1, 16'h7777}) begin
      n_err++; $display("FAIL indep_wr: got %b/%h %b/%h want 1/7777", o.v1, o.d1, o.v2, o.d2);
    end
  endtask

  task automatic test_out_of_range();
    step(1'b0, 1'b1, 1'b1, 12'h900, 16'hFFFF, 2'b11, 1'b0, 12'h0);
    step(1'b0, 1'b1, 1'b0, 12'h0, 16'h0, 2'b00, 1'b1, 12'h100);
    idle();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({b2.rd_valid, b2.rd_data} !== {1'b1, 16'h0000}) begin
      n_err++; $display("FAIL oor_no_alias: got %b/%h want 1/0000", b2.rd_valid, b2.rd_data);
    end
    step(1'b0, 1'b1, 1'b0, 12'h0, 16'h0, 2'b00, 1'b1, 12'h010);
    step(1'b0, 1'b1, 1'b0, 12'h0, 16'h0, 2'b00, 1'b1, 12'h900);
    idle();
    @(negedge clk);
    n_cmp++;
    if ({b2.rd_valid, b2.rd_data} !== {1'b1, 16'h5634}) begin
      n_err++; $display("FAIL oor_prev: got %b/%h want 1/5634", b2.rd_valid, b2.rd_data);
    end
    @(negedge clk);
    n_cmp++;
    if ({b2.rd_valid, b2.rd_data} !== {1'b1, 16'h0000}) begin
      n_err++; $display("FAIL oor_read: got %b/%h want 1/0000", b2.rd_valid, b2.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  exp_v1;
    logic [5:0]  exp_v2;
    logic [15:0] e1;
    logic [15:0] e2;
    exp_v1 = 6'b001110;
    exp_v2 = 6'b011100;
    step(1'b1, 1'b1, 1'b1, 12'h001, 16'h0001, 2'b11, 1'b0, 12'h0);
    step(1'b1, 1'b1, 1'b1, 12'h002, 16'h0002, 2'b11, 1'b0, 12'h0);
    step(1'b1, 1'b1, 1'b1, 12'h003, 16'h0003, 2'b11, 1'b0, 12'h0);
    for (int k = 0; k < 6; k++) begin
      if (k < 3) drive(1'b1, 1'b1, 1'b0, 12'h0, 16'h0, 2'b00, 1'b1, 12'(k + 1));
      else       idle();
      @(negedge clk);
      e1 = 16'(k);
      e2 = 16'(k - 1);
      n_cmp++;
      if (b1.rd_valid !== exp_v1[k] || (exp_v1[k] && b1.rd_data !== e1)) begin
        n_err++; $display("FAIL b2b_l1 edge+%0d: got %b/%h want %b/%h", k, b1.rd_valid, b1.rd_data, exp_v1[k], e1);
      end
      n_cmp++;
      if (b2.rd_valid !== exp_v2[k] || (exp_v2[k] && b2.rd_data !== e2)) begin
        n_err++; $display("FAIL b2b_l2 edge+%0d: got %b/%h want %b/%h", k, b2.rd_valid, b2.rd_data, exp_v2[k], e2);
      end
    end
  endtask

  task automatic test_reset_mid_init();
    obs_t o;
    int   cnt;
    int   seen;
    step(1'b1, 1'b1, 1'b0, 12'h0, 16'h0, 2'b00, 1'b1, 12'h010);
    rst = 1'b1;
    idle();
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({b1.rd_valid, b2.rd_valid, b1.rd_data, b2.rd_data} !== 34'h0) begin
        n_err++; $display("FAIL flush: got v=%b%b d=%h/%h want 00 0000/0000", b1.rd_valid, b2.rd_valid, b1.rd_data, b2.rd_data);
      end
    end
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 12'h7FF, 16'hFFFF, 2'b11, 1'b1, 12'h7FF);
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (b1.rd_valid === 1'b1 || b2.rd_valid === 1'b1 || b1.ready === 1'b1) seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (b1.ready !== 1'b1 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
      if (b1.rd_valid === 1'b1 || b2.rd_valid === 1'b1) seen++;
    end
    idle();
    n_cmp++;
    if (cnt !== 2048) begin
      n_err++; $display("FAIL reinit_duration: ready after %0d edges want 2048", cnt);
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++; $display("FAIL init_ignores_req: saw %0d strobes during init want 0", seen);
    end
    xact(1'b0, 12'h0, 16'h0, 2'b00, 12'h7FF, o);
    n_cmp++;
    if ({o.v1, o.d1, o.v2, o.d2} !== {1'b1, 16'h0000, 1'b1, 16'h0000}) begin
      n_err++; $display("FAIL reinit_read_7ff: got %b/%h %b/%h want 1/0000 1/0000", o.v1, o.d1, o.v2, o.d2);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_basic_rw();
    test_byte_enable();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_dp.md
# sram_dp

Parametrised simple-dual-port synchronous SRAM with one write port and one read port. It adds per-byte write enables, a configurable registered read latency with a valid strobe, and a hardware zero-initialisation sequencer that runs after every reset. It is the standard on-chip buffer for datapath blocks. There is no tri-state bus: data in and data out are separate ports.

## Interface
Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 11, address width.
- MEM_DEPTH, 2048, number of words; must be ≤ 2^ADDR_WIDTH.
- RD_LATENCY, 1, read latency in cycles; legal values are 1 or 2.

Ports (BE_WIDTH = DATA_WIDTH/8):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ready  out  1  high once initialisation is complete; requests are accepted only while high.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  BE_WIDTH  byte enables; bit i covers data bits [8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle strobe marking rd_data as valid.

## Operation
- Controller FSM has two states, INIT and READY.
- Asserting rst (async) forces:
  - state = INIT, init pointer = 0;
  - ready = 0, rd_valid = 0, rd_data = 0;
  - the read pipeline is flushed.
- INIT: on each clock edge after rst falls, write all-zero to mem[init_ptr] and increment init_ptr.
  - On the edge that writes MEM_DEPTH-1, go to READY and set ready = 1.
  - wr_en and rd_en are ignored throughout INIT.
- READY: a write is accepted when wr_en = 1.
  - Only bytes with wr_be[i] = 1 are updated; other bytes keep their value.
  - wr_be = 0 is a no-op.
- READY: a read is accepted when rd_en = 1.
- Out-of-range address (≥ MEM_DEPTH):
  - writes are dropped;
  - reads still produce rd_valid, with rd_data = 0.
- rd_data holds its last valid value while rd_valid = 0.
- Read and write on different addresses in the same cycle are fully independent.
- Same-address read and write in the same cycle: the result is set by the configuration macro (see Configuration).
- rst asserted mid-INIT restarts initialisation from address 0.
- rst asserted in READY discards in-flight reads; no rd_valid is produced for them.

## Timing
- Init duration: exactly MEM_DEPTH cycles after rst deasserts.
  - ready is registered high on the edge that performs the MEM_DEPTH-th init write.
  - The first request is accepted on the following edge.
- Write: memory is updated on the accepting edge. A read accepted on any later edge sees the new data.
- Read accepted on edge N:
  - rd_valid = 1 and rd_data valid after edge N+RD_LATENCY, for one cycle.
- Reads are fully pipelined: one read per cycle, with results in request order.
- RD_LATENCY = 2 adds an output register stage; rd_valid is delayed to match.

## Configuration
- SRAM_BYPASS_EN defined: a same-cycle, same-address read returns the new data.
  - Enabled bytes come from wr_data; the rest come from the old word.
  - This is write-first behaviour.
- SRAM_BYPASS_EN undefined: a same-cycle, same-address read returns the pre-write word (read-first behaviour). No forwarding logic is built.

## Structure
- Package sram_pkg holds:
  - the state typedef (INIT, READY);
  - the helper constant BE_WIDTH derivation;
  - the legality-check localparams for RD_LATENCY and DATA_WIDTH%8.
- Sub-module sram_init_ctrl owns the INIT/READY FSM and the init pointer. Its outputs are ready, init_we and init_addr.
- The top level sram_dp holds the array, the byte-merge logic, the read pipeline and the optional bypass.

## Test plan
- Init: pulse rst, release, then poll ready.
  - ready = 0 for 2047 edges and goes high after edge 2048.
  - A read of 0x005 returns 0x0000.
- Basic write/read (RD_LATENCY = 1): write 0xBEEF to 0x010 with be = 2'b11, then read 0x010 on the next edge.
  - One edge later: rd_valid = 1, rd_data = 0xBEEF.
- Byte enable: write 0x1234 to 0x010 with be = 2'b01, then read 0x010.
  - rd_data = 0xBE34.
- Collision: with mem[0x020] = 0x5555, write 0xAAAA and read 0x020 on the same edge.
  - With SRAM_BYPASS_EN: rd_data = 0xAAAA. Without it: rd_data = 0x5555.
- Reset during INIT: assert rst at init cycle 100, then release.
  - ready stays low for a full 2048 cycles after the second release.
  - Address 0x7FF reads 0x0000.
- Pipelined read (RD_LATENCY = 2): preload addresses 1, 2, 3 with 0x0001, 0x0002, 0x0003, then issue back-to-back reads on edges N, N+1, N+2.
  - rd_valid is high on N+2..N+4 with data 0x0001, 0x0002, 0x0003.
  - A read of 0x900 returns 0x0000 with rd_valid = 1.
